// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: frame width, controller state
//               encoding and the parity helper used by both RX and TX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Data bits carried by one frame (start/parity/stop excluded)
  localparam int FRAME_DATA_BITS = 8;

  // Controller state encoding, shared with the TX controller
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_PARITY    = 3'd3;
  localparam uart_state_t ST_STOP      = 3'd4;
  localparam uart_state_t ST_WAIT_IDLE = 3'd5;

  // Parity bit for a data byte: even -> XOR of bits, odd -> XNOR of bits
  function automatic logic parity_calc(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic                       odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for an asynchronous single-bit input.
//               Resets to RESET_VAL so an idle-high line reads idle at once.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic reg_clk,
  input  logic reg_rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;

  // Two back-to-back flops; the first may go metastable, the second settles
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      r_meta   <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      r_meta   <= async_in;
      sync_out <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo
// Description : UART receiver. Oversamples the serial line, recovers
//               start/8 data/parity/stop frames, checks parity and stop, and
//               hands each byte to the host through a valid/ready register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                       reg_clk,
  input  logic                       reg_rst_n,
  input  logic                       serial_in,
  input  logic                       rx_ready,
  output logic [FRAME_DATA_BITS-1:0] rx_data,
  output logic                       rx_valid,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun_err,
  output logic                       rx_busy
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] c_tick_half = TICK_W'(HALF - 1);

  logic                       w_rx_s;
  uart_state_t                r_state;
  logic [TICK_W-1:0]          r_tick_cnt;
  logic [2:0]                 r_bit_idx;
  logic [FRAME_DATA_BITS-1:0] r_shift_reg;
  logic                       r_par_bit;
  logic                       r_stop_sample;
  logic                       r_commit;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .reg_clk   (reg_clk),
    .reg_rst_n (reg_rst_n),
    .async_in  (serial_in),
    .sync_out  (w_rx_s)
  );

  // Frame recovery: bit timing, serial-to-parallel shift, stop-bit commit pulse
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= '0;
      r_bit_idx     <= '0;
      r_shift_reg   <= '0;
      r_par_bit     <= 1'b0;
      r_stop_sample <= 1'b0;
      r_commit      <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (r_tick_cnt == c_tick_half) begin
            r_tick_cnt <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt             <= '0;
            r_shift_reg[r_bit_idx] <= w_rx_s;
            r_bit_idx              <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
            r_par_bit  <= w_rx_s;
            r_state    <= ST_STOP;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // The cycle after the stop sample is the commit cycle
          if (r_commit) begin
            r_state <= r_stop_sample ? ST_IDLE : ST_WAIT_IDLE;
          end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt    <= '0;
            r_stop_sample <= w_rx_s;
            r_commit      <= 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line (break) must not look like a new start bit
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register: load on commit when free or being drained, else flag overrun
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (r_commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= r_shift_reg;
          rx_valid   <= 1'b1;
          parity_err <= (r_par_bit != parity_calc(r_shift_reg, PARITY_ODD));
          frame_err  <= ~r_stop_sample;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

  assign rx_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo
// Description : Self-checking bench for uart_rx_sipo. Drives serial frames,
//               queues the expected byte/flags per accepted frame and checks
//               each holding-register load; even and odd parity builds run
//               side by side on the same line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Clock edges from the line falling edge to the commit edge
  localparam int COMMIT_NEG = 3 + HALF + 10 * CPB + 1;

  logic       reg_clk = 1'b0;
  logic       reg_rst_n;
  logic       serial_in;
  logic       rx_ready;
  logic [7:0] rx_data_e,     rx_data_o;
  logic       rx_valid_e,    rx_valid_o;
  logic       parity_err_e,  parity_err_o;
  logic       frame_err_e,   frame_err_o;
  logic       overrun_err_e, overrun_err_o;
  logic       rx_busy_e,     rx_busy_o;

  always #5 reg_clk = ~reg_clk;

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
    .reg_clk     (reg_clk),
    .reg_rst_n   (reg_rst_n),
    .serial_in   (serial_in),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data_e),
    .rx_valid    (rx_valid_e),
    .parity_err  (parity_err_e),
    .frame_err   (frame_err_e),
    .overrun_err (overrun_err_e),
    .rx_busy     (rx_busy_e)
  );

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .reg_clk     (reg_clk),
    .reg_rst_n   (reg_rst_n),
    .serial_in   (serial_in),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data_o),
    .rx_valid    (rx_valid_o),
    .parity_err  (parity_err_o),
    .frame_err   (frame_err_o),
    .overrun_err (overrun_err_o),
    .rx_busy     (rx_busy_o)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr_even;
    logic       perr_odd;
    logic       ferr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Drive the first nbits of a frame, LSB (start bit) first, CPB cycles each
  task automatic drive_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge reg_clk);
      serial_in = frame[i];
      repeat (CPB - 1) @(negedge reg_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic expect_load);
    exp_t e;
    if (expect_load) begin
      e.data      = d;
      e.perr_even = par ^ (^d);
      e.perr_odd  = par ^ (~^d);
      e.ferr      = ~stop;
      sb_q.push_back(e);
    end
    drive_bits(mk_frame(d, par, stop), 11);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge reg_clk);
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_ready(input string tag);
    @(negedge reg_clk);
    rx_ready = 1'b1;
    @(negedge reg_clk);
    rx_ready = 1'b0;
    check(tag, 32'(rx_valid_e), 32'd0);
  endtask

  // Scoreboard monitor: a load is a rising rx_valid or valid held across a ready edge
  logic prev_valid = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge reg_clk);
      #2;
      if (rx_valid_e && (!prev_valid || rx_ready)) begin
        if (sb_q.size() == 0) begin
          check("spurious_load", 32'(rx_valid_e), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("even_data",  32'(rx_data_e),    32'(mon_e.data));
          check("even_perr",  32'(parity_err_e), 32'(mon_e.perr_even));
          check("even_ferr",  32'(frame_err_e),  32'(mon_e.ferr));
          check("odd_valid",  32'(rx_valid_o),   32'd1);
          check("odd_data",   32'(rx_data_o),    32'(mon_e.data));
          check("odd_perr",   32'(parity_err_o), 32'(mon_e.perr_odd));
          check("odd_ferr",   32'(frame_err_o),  32'(mon_e.ferr));
        end
      end
      prev_valid = rx_valid_e;
    end
  end

  // Hard stop if the sequence never completes
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    logic [7:0] v;
    reg_rst_n = 1'b0;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(negedge reg_clk);
    check("rst_data",    32'(rx_data_e),     32'd0);
    check("rst_valid",   32'(rx_valid_e),    32'd0);
    check("rst_perr",    32'(parity_err_e),  32'd0);
    check("rst_ferr",    32'(frame_err_e),   32'd0);
    check("rst_overrun", 32'(overrun_err_e), 32'd0);
    check("rst_busy",    32'(rx_busy_e),     32'd0);
    check("rst_busy_o",  32'(rx_busy_o),     32'd0);
    reg_rst_n = 1'b1;
    repeat (4) @(negedge reg_clk);

    // Good frame with correct even parity
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_a5", 4 * CPB);
    check("a5_valid_held", 32'(rx_valid_e), 32'd1);
    check("a5_data_held",  32'(rx_data_e),  32'hA5);
    pulse_ready("a5_ready_clear");

    // Wrong parity for even, right for odd
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_3c", 4 * CPB);
    check("3c_perr_even", 32'(parity_err_e), 32'd1);
    check("3c_perr_odd",  32'(parity_err_o), 32'd0);
    pulse_ready("3c_ready_clear");

    // Framing error followed by a held-low break
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (40 - CPB) @(negedge reg_clk);
    wait_drain("drain_81", 4 * CPB);
    check("break_busy", 32'(rx_busy_e),   32'd1);
    check("81_ferr",    32'(frame_err_e), 32'd1);
    serial_in = 1'b1;
    repeat (6) @(negedge reg_clk);
    check("break_end_busy", 32'(rx_busy_e), 32'd0);
    pulse_ready("81_ready_clear");
    repeat (2 * CPB) @(negedge reg_clk);
    check("break_no_second", 32'(rx_valid_e), 32'd0);

    // Short low glitch: start detected, then rejected at mid-bit
    @(negedge reg_clk);
    serial_in = 1'b0;
    repeat (4) @(negedge reg_clk);
    serial_in = 1'b1;
    check("glitch_start_busy", 32'(rx_busy_e), 32'd1);
    repeat (20) @(negedge reg_clk);
    check("glitch_idle_busy", 32'(rx_busy_e),  32'd0);
    check("glitch_no_valid",  32'(rx_valid_e), 32'd0);

    // Overrun: second frame dropped while the first is unread
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge reg_clk);
    check("ovr_flag_even", 32'(overrun_err_e), 32'd1);
    check("ovr_flag_odd",  32'(overrun_err_o), 32'd1);
    check("ovr_data_kept", 32'(rx_data_e),     32'h11);
    check("ovr_valid",     32'(rx_valid_e),    32'd1);

    // Read and new commit on the same edge: new byte replaces old
    fork
      send_frame(8'h33, 1'b0, 1'b1, 1'b1);
      begin
        repeat (COMMIT_NEG) @(negedge reg_clk);
        rx_ready = 1'b1;
        @(negedge reg_clk);
        rx_ready = 1'b0;
      end
    join
    wait_drain("drain_33", 4 * CPB);
    check("swap_data",    32'(rx_data_e),     32'h33);
    check("swap_valid",   32'(rx_valid_e),    32'd1);
    check("swap_overrun", 32'(overrun_err_e), 32'd1);
    pulse_ready("33_ready_clear");

    // Reset in the middle of data bit 4 of a frame
    v = 8'h5A;
    drive_bits(mk_frame(v, 1'b0, 1'b1), 5);
    @(negedge reg_clk);
    serial_in = v[4];
    repeat (8) @(negedge reg_clk);
    reg_rst_n = 1'b0;
    #1;
    check("midrst_busy",    32'(rx_busy_e),     32'd0);
    check("midrst_overrun", 32'(overrun_err_e), 32'd0);
    check("midrst_data",    32'(rx_data_e),     32'd0);
    repeat (3) @(negedge reg_clk);
    serial_in = 1'b1;
    repeat (2) @(negedge reg_clk);
    reg_rst_n = 1'b1;
    repeat (4) @(negedge reg_clk);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_96", 4 * CPB);
    check("96_data",    32'(rx_data_e),     32'h96);
    check("96_perr",    32'(parity_err_e),  32'd0);
    check("96_ferr",    32'(frame_err_e),   32'd0);
    check("96_overrun", 32'(overrun_err_e), 32'd0);

    repeat (10) @(negedge reg_clk);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
